usr_sw_debounce: RTL and testbench
==================================

# usr_sw_debounce

Debounced reader for the board DIP switches (`usr_sw`), on the input side of the same user-I/O path that drives `led`. It synchronizes each raw switch bit into `sys0_clk` and filters contact bounce with a per-bit stability counter. It publishes the debounced word continuously and emits a change event on a valid/ready handshake. It sits beside the top-level I/O, between the `usr_sw` pads and control logic.

## Interface
- `WIDTH`, 8: number of switch bits.
- `DEBOUNCE_CYCLES`, 200000: consecutive stable cycles required before accepting a new level (1 ms at 200 MHz). Must be ≥ 2.
- `CNT_W`, 18: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `sys0_clk`  in  1  single clock; all logic on the rising edge.
- `sys0_rstn`  in  1  reset, synchronous and active-low.
- `usr_sw_i`  in  WIDTH  raw asynchronous switch inputs.
- `sw_stable`  out  WIDTH  debounced switch word.
- `evt_valid`  out  1  change event pending.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_sw`  out  WIDTH  `sw_stable` value at the latest change folded into the event.
- `evt_mask`  out  WIDTH  OR of every bit that toggled since the last accepted event.

## Operation
- **Synchronizer.** Each bit passes through a two-flop chain, `s1` then `s2`. Only `s2` is used downstream.
- **Per-bit counter `cnt[i]`.**
  - If `s2[i] == sw_stable[i]`: `cnt[i]` ← 0.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_stable[i]` ← `s2[i]`, `cnt[i]` ← 0, and bit i is flagged as toggled this cycle (`tog[i]`).
  - Otherwise: `cnt[i]` ← `cnt[i]+1`.
  - Bits are fully independent. No wrap is possible, because the counter is cleared at the terminal value.
- **Event register.** Let `chg` = `tog` ≠ 0.
  - Idle (`evt_valid`=0), `chg`=1: `evt_valid` ← 1, `evt_mask` ← `tog`, `evt_sw` ← new `sw_stable`.
  - Pending, not accepted (`evt_valid`=1, `evt_ready`=0), `chg`=1: `evt_mask` ← `evt_mask | tog`, `evt_sw` ← new `sw_stable`. No event is lost; changes coalesce.
  - Accept (`evt_valid`=1, `evt_ready`=1), `chg`=0: `evt_valid` ← 0, `evt_mask` ← 0.
  - Accept and `chg`=1 in the same cycle: the consumed event is retired. A fresh event is loaded with `evt_mask` ← `tog` only, and `evt_valid` stays 1.
  - `evt_ready` while `evt_valid`=0 is ignored.
- **Payload stability.** `evt_sw` and `evt_mask` hold steady while `evt_valid`=1 and no new toggle occurs.
- **Reset.** A low `sys0_rstn` sampled at any clock edge, including mid-count or with an event pending, clears all state next edge:
  - `s1`, `s2`, `cnt`, `sw_stable`, `evt_sw`, `evt_mask` ← 0
  - `evt_valid` ← 0
  - After reset, any switch that is ON produces a normal debounced event.

## Timing
- **Outputs.** All outputs are registered. There is no combinational path from `evt_ready` or `usr_sw_i` to any output.
- **Latency.** Input changes and then holds from before edge E.
  - `s2` reflects it after edge E+1.
  - `sw_stable`, `evt_valid`, `evt_mask` and `evt_sw` update at edge E+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges counting E.
- **Glitch rejection.** A level change held in `s2` for fewer than DEBOUNCE_CYCLES consecutive cycles never reaches `sw_stable`, and its counter restarts from 0.
- **Throughput.** One event accept per cycle at most. A handshake completes on any edge with `evt_valid` & `evt_ready` both 1.

## Test plan
Use DEBOUNCE_CYCLES=4 and WIDTH=8 throughout.
1. **Reset.** Hold `sys0_rstn`=0 for 3 cycles with `usr_sw_i`=8'hA5 -> all outputs 0. Release reset and keep `evt_ready`=0 -> `sw_stable`=8'hA5, `evt_valid`=1, `evt_mask`=8'hA5 and `evt_sw`=8'hA5 at exactly 6 edges after the first edge where rstn=1 is sampled.
2. **Bounce rejection.** From stable 8'h00, pulse bit 0 high for 3 cycles, low for 1, then high steadily -> `sw_stable[0]` rises 6 edges after the final rise, with no earlier change and exactly one event with `evt_mask`=8'h01.
3. **Coalescing.** Keep `evt_ready`=0 and toggle bit 1, then bit 5 ten cycles later -> single event, `evt_mask`=8'h22, `evt_sw`=8'h22. Assert `evt_ready` one cycle -> `evt_valid`=0 and `evt_mask`=0 the next edge.
4. **Simultaneous accept and toggle.** Pending `evt_mask`=8'h01; bit 7 toggle lands on the accept edge -> `evt_valid` stays 1 and `evt_mask`=8'h80 (not 8'h81).
5. **Reset mid-operation.** Event pending and bit 3 counter at 2: assert rstn=0 for one edge -> `evt_valid`=0, `sw_stable`=0, counters 0. The debounce then restarts from zero.
6. **Idle ready.** Hold `evt_ready`=1 continuously with no input activity for 20 cycles -> `evt_valid` stays 0 and outputs are unchanged.

Source files
------------

// File: rtl/usr_sw_debounce.sv
// Switch debouncer for the user DIP switches.
// Each raw bit is brought into sys0_clk through a two-flop synchronizer. It is
// accepted as a new level only after it has differed from the published level
// for DEBOUNCE_CYCLES consecutive cycles. Accepted changes are folded into a
// single pending event on a valid/ready handshake.
module usr_sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18
) (
  input  logic             sys0_clk,
  input  logic             sys0_rstn,
  input  logic [WIDTH-1:0] usr_sw_i,
  output logic [WIDTH-1:0] sw_stable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_sw,
  output logic [WIDTH-1:0] evt_mask
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_sw;
  logic [WIDTH-1:0] r_evt_mask;

  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic             w_chg;
  logic             w_evt_valid_nxt;
  logic [WIDTH-1:0] w_evt_sw_nxt;
  logic [WIDTH-1:0] w_evt_mask_nxt;

  // Per-bit stability counters: a bit that agrees with the published level
  // clears its counter. The counter is cleared again at the terminal count,
  // which is also where the new level is accepted, so it can never wrap.
  always_comb begin
    w_tog        = '0;
    w_stable_nxt = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_nxt[i] = r_s2[i];
          w_tog[i]        = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event register: an accept retires the current event, and any toggle in the
  // same cycle either opens a fresh event or coalesces into the pending one.
  always_comb begin
    w_chg           = (w_tog != '0);
    w_evt_valid_nxt = r_evt_valid;
    w_evt_sw_nxt    = r_evt_sw;
    w_evt_mask_nxt  = r_evt_mask;
    if (r_evt_valid && evt_ready) begin
      w_evt_valid_nxt = 1'b0;
      w_evt_mask_nxt  = '0;
      if (w_chg) begin
        w_evt_valid_nxt = 1'b1;
        w_evt_mask_nxt  = w_tog;
        w_evt_sw_nxt    = w_stable_nxt;
      end
    end else if (w_chg) begin
      w_evt_valid_nxt = 1'b1;
      w_evt_mask_nxt  = r_evt_valid ? (r_evt_mask | w_tog) : w_tog;
      w_evt_sw_nxt    = w_stable_nxt;
    end
  end

  // State registers: the synchronizer, the counters and the event all clear on reset.
  always_ff @(posedge sys0_clk) begin
    if (!sys0_rstn) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_stable    <= '0;
      r_evt_valid <= 1'b0;
      r_evt_sw    <= '0;
      r_evt_mask  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1        <= usr_sw_i;
      r_s2        <= r_s1;
      r_stable    <= w_stable_nxt;
      r_evt_valid <= w_evt_valid_nxt;
      r_evt_sw    <= w_evt_sw_nxt;
      r_evt_mask  <= w_evt_mask_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign sw_stable = r_stable;
  assign evt_valid = r_evt_valid;
  assign evt_sw    = r_evt_sw;
  assign evt_mask  = r_evt_mask;

endmodule

// File: tb/tb_usr_sw_debounce.sv
// Randomized and directed bench for usr_sw_debounce, checked every cycle
// against a run-length reference model of the debouncer and its event.
module tb_usr_sw_debounce;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] sw_i = '0;
  logic         ready = 1'b0;
  logic [W-1:0] sw_stable;
  logic         evt_valid;
  logic [W-1:0] evt_sw;
  logic [W-1:0] evt_mask;

  usr_sw_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW)
  ) dut (
    .sys0_clk (clk),
    .sys0_rstn(rstn),
    .usr_sw_i (sw_i),
    .sw_stable(sw_stable),
    .evt_valid(evt_valid),
    .evt_ready(ready),
    .evt_sw   (evt_sw),
    .evt_mask (evt_mask)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples age through a two-deep history; a bit is
  // accepted once its synchronized value has disagreed with the published
  // level on D consecutive edges.
  logic [W-1:0] m_hist [2];
  logic [W-1:0] m_stable;
  logic         m_valid;
  logic [W-1:0] m_sw;
  logic [W-1:0] m_mask;
  int           m_run [W];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] seen;
    logic [W-1:0] tog;
    if (!rstn) begin
      m_hist[0] = '0;
      m_hist[1] = '0;
      m_stable  = '0;
      m_valid   = 1'b0;
      m_sw      = '0;
      m_mask    = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      seen = m_hist[1];
      tog  = '0;
      for (int i = 0; i < W; i++) begin
        if (seen[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = seen[i];
            m_run[i]    = 0;
            tog[i]      = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (m_valid && ready) begin
        m_valid = 1'b0;
        m_mask  = '0;
      end
      if (tog != '0) begin
        m_mask  = m_valid ? (m_mask | tog) : tog;
        m_valid = 1'b1;
        m_sw    = m_stable;
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = sw_i;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_val("sw_stable", sw_stable, m_stable);
    chk_val("evt_valid", evt_valid, m_valid);
    chk_val("evt_sw",    evt_sw,    m_sw);
    chk_val("evt_mask",  evt_mask,  m_mask);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int b;
    // Reset with switches on, then release and watch the first event arrive.
    rstn = 1'b0; sw_i = 8'hA5; ready = 1'b0;
    run(3);
    chk_val("rst_stable", sw_stable, 8'h00);
    chk_val("rst_valid",  evt_valid, 1'b0);
    chk_val("rst_mask",   evt_mask,  8'h00);
    chk_val("rst_sw",     evt_sw,    8'h00);
    rstn = 1'b1;
    run(5);
    chk_val("rel_early_valid", evt_valid, 1'b0);
    run(1);
    chk_val("rel_stable", sw_stable, 8'hA5);
    chk_val("rel_valid",  evt_valid, 1'b1);
    chk_val("rel_mask",   evt_mask,  8'hA5);
    chk_val("rel_sw",     evt_sw,    8'hA5);

    // Bounce rejection on bit 0.
    rstn = 1'b0; sw_i = 8'h00;
    run(2);
    rstn = 1'b1;
    run(3);
    sw_i = 8'h01; run(3);
    sw_i = 8'h00; run(1);
    sw_i = 8'h01; run(5);
    chk_val("bnc_early_stable", sw_stable, 8'h00);
    chk_val("bnc_early_valid",  evt_valid, 1'b0);
    run(1);
    chk_val("bnc_stable", sw_stable, 8'h01);
    chk_val("bnc_mask",   evt_mask,  8'h01);
    ready = 1'b1; run(1); ready = 1'b0;
    run(8);
    chk_val("bnc_one_event", evt_valid, 1'b0);

    // Coalescing of two toggles into one pending event.
    rstn = 1'b0; sw_i = 8'h00;
    run(2);
    rstn = 1'b1;
    run(2);
    sw_i = 8'h02; run(10);
    sw_i = 8'h22; run(10);
    chk_val("coal_valid", evt_valid, 1'b1);
    chk_val("coal_mask",  evt_mask,  8'h22);
    chk_val("coal_sw",    evt_sw,    8'h22);
    ready = 1'b1; run(1); ready = 1'b0;
    chk_val("coal_acc_valid", evt_valid, 1'b0);
    chk_val("coal_acc_mask",  evt_mask,  8'h00);

    // Accept on the same edge that bit 7 is accepted.
    sw_i = 8'h23; run(8);
    chk_val("sim_pend_mask", evt_mask, 8'h01);
    sw_i = 8'hA3; run(5);
    ready = 1'b1; run(1); ready = 1'b0;
    chk_val("sim_valid", evt_valid, 1'b1);
    chk_val("sim_mask",  evt_mask,  8'h80);
    chk_val("sim_sw",    evt_sw,    8'hA3);

    // Reset while an event is pending and bit 3 is mid-count.
    sw_i = 8'hAB; run(4);
    rstn = 1'b0; run(1); rstn = 1'b1;
    chk_val("mid_rst_valid",  evt_valid, 1'b0);
    chk_val("mid_rst_stable", sw_stable, 8'h00);
    chk_val("mid_rst_mask",   evt_mask,  8'h00);
    run(5);
    chk_val("mid_restart_early", evt_valid, 1'b0);
    run(1);
    chk_val("mid_restart_mask",   evt_mask,  8'hAB);
    chk_val("mid_restart_stable", sw_stable, 8'hAB);

    // Ready held high with no input activity.
    ready = 1'b1; run(1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk_val("idle_valid",  evt_valid, 1'b0);
      chk_val("idle_stable", sw_stable, 8'hAB);
      chk_val("idle_mask",   evt_mask,  8'h00);
    end
    ready = 1'b0;

    // Randomized phase: sparse bit flips, random ready, rare resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, W - 1));
        sw_i[b] = ~sw_i[b];
      end
      ready = ($urandom_range(0, 3) == 0);
      rstn  = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
